// File: rtl/counter_arbiter_pkg.sv
// Shared types and default sizing for the counter arbiter.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int unsigned COUNTER_ARB_WIDTH_DEF = 8;
  localparam int unsigned COUNTER_ARB_NREQ_DEF  = 4;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot winner from the request vector and a pointer
// holding the last winner; the search starts one position past the pointer.
module rr_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = COUNTER_ARB_NREQ_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_update,
  output logic [N_REQ-1:0] o_winner,
  output logic             o_any
);

  localparam int unsigned     PW   = $clog2(N_REQ);
  localparam logic [PW-1:0]   LAST = PW'(N_REQ - 1);

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_cand;
  int unsigned      w_sum;
  logic             w_found;
  logic [N_REQ-1:0] w_winner;

  // Scan candidates ptr+1 .. ptr+N_REQ (mod N_REQ); first asserted request wins.
  always_comb begin
    w_winner = '0;
    w_idx    = r_ptr;
    w_cand   = '0;
    w_sum    = 0;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_sum  = (32'(r_ptr) + k) % N_REQ;
      w_cand = PW'(w_sum);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        w_winner[w_cand] = 1'b1;
        w_idx            = w_cand;
      end
    end
  end

  assign o_winner = w_winner;
  assign o_any    = w_found;

  // Pointer remembers the last winner; reset value makes requester 0 next.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= LAST;
    end else if (i_update) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Time-shares one up-counter between N_REQ requesters, granted round-robin.
// Optional feature macro: COUNTER_ARBITER_ABORT_EN adds abort/aborted.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = COUNTER_ARB_NREQ_DEF,
  parameter int unsigned WIDTH = COUNTER_ARB_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_limit,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       value
`ifdef COUNTER_ARBITER_ABORT_EN
  ,
  input  logic                   abort,
  output logic                   aborted
`endif
);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_done,  w_done_nxt;
  logic [WIDTH-1:0] r_value, w_value_nxt;
  logic [WIDTH-1:0] r_lim,   w_lim_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic             w_take;
  logic [N_REQ-1:0] w_winner;
  logic             w_any;
  logic [WIDTH-1:0] w_lim_sel;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_req    (req),
    .i_update (w_take),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Select the winner's terminal count slice (winner is one-hot or zero).
  always_comb begin
    w_lim_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_winner[i]) begin
        w_lim_sel = req_limit[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_done_nxt    = '0;
    w_value_nxt   = r_value;
    w_lim_nxt     = r_lim;
    w_aborted_nxt = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take      = 1'b1;
          w_grant_nxt = w_winner;
          w_lim_nxt   = w_lim_sel;
          w_value_nxt = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Reaching the terminal count takes precedence over a same-edge abort.
        if (r_value == r_lim) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_grant;
        end
`ifdef COUNTER_ARBITER_ABORT_EN
        else if (abort) begin
          w_state_nxt   = DONE;
          w_done_nxt    = r_grant;
          w_aborted_nxt = 1'b1;
        end
`endif
        else begin
          w_value_nxt = r_value + WIDTH'(1);
        end
      end
      DONE: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any interval without a done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_value   <= '0;
      r_lim     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_value   <= w_value_nxt;
      r_lim     <= w_lim_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign value = r_value;

`ifdef COUNTER_ARBITER_ABORT_EN
  assign aborted = r_aborted;
`else
  logic w_unused;
  assign w_unused = r_aborted;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: table-driven single grants,
// directed corner sequences and randomized traffic against a reference model.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_limit;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;
  logic [W-1:0]     value;
  logic             abort;
  logic             aborted;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the counter, its count, and whether this is
  // the completion cycle.
  int m_owner;
  int m_val;
  int m_lim;
  int m_last;
  bit m_fin;
  bit m_ab;

  always #5 clk = ~clk;

  counter_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_limit (req_limit),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .value     (value)
`ifdef COUNTER_ARBITER_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

`ifndef COUNTER_ARBITER_ABORT_EN
  assign aborted = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_val   = 0;
    m_lim   = 0;
    m_last  = N - 1;
    m_fin   = 1'b0;
    m_ab    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int c;
    bit ab_in;
`ifdef COUNTER_ARBITER_ABORT_EN
    ab_in = abort;
`else
    ab_in = 1'b0;
`endif
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
          m_lim   = int'(req_limit[c*W +: W]);
          m_val   = 0;
        end
      end
    end else if (m_fin) begin
      m_owner = -1;
      m_fin   = 1'b0;
      m_ab    = 1'b0;
    end else if (m_val == m_lim) begin
      m_fin = 1'b1;
    end else if (ab_in) begin
      m_fin = 1'b1;
      m_ab  = 1'b1;
    end else begin
      m_val = m_val + 1;
    end
  endtask

  task automatic compare_all();
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("grant", int'(grant), eg);
    check("done",  int'(done),  m_fin ? eg : 0);
    check("busy",  int'(busy),  (m_owner >= 0) ? 1 : 0);
    check("value", int'(value), m_val);
`ifdef COUNTER_ARBITER_ABORT_EN
    check("aborted", int'(aborted), m_ab ? 1 : 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_lim(input int i, input int l);
    logic [W-1:0] lv;
    lv = W'(l);
    req_limit[i*W +: W] = lv;
  endtask

  // Asynchronous reset pulse issued between edges, checked before release.
  task automatic pulse_reset(input string name);
    #2;
    reset = 1'b1;
    #1;
    check({name, "_grant"}, int'(grant), 0);
    check({name, "_done"},  int'(done),  0);
    check({name, "_busy"},  int'(busy),  0);
    check({name, "_value"}, int'(value), 0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_value(input int v);
    int n;
    n = 0;
    while (int'(value) != v && n < 400) begin
      step();
      n++;
    end
    check("wait_value", int'(value), v);
  endtask

  typedef struct {
    int         idx;
    int         lim;
    logic [3:0] exp_grant;
    int         exp_done_ofs;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cnt;
    int order[5];
    int when[5];
    int nfound;
    int cyc;
    logic [N-1:0] prevg;

    tbl[0] = '{idx: 2, lim: 3,   exp_grant: 4'b0100, exp_done_ofs: 4};
    tbl[1] = '{idx: 0, lim: 0,   exp_grant: 4'b0001, exp_done_ofs: 1};
    tbl[2] = '{idx: 3, lim: 255, exp_grant: 4'b1000, exp_done_ofs: 256};
    tbl[3] = '{idx: 1, lim: 7,   exp_grant: 4'b0010, exp_done_ofs: 8};
    tbl[4] = '{idx: 2, lim: 1,   exp_grant: 4'b0100, exp_done_ofs: 2};

    req       = '0;
    req_limit = '0;
    abort     = 1'b0;
    reset     = 1'b1;
    model_reset();
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_done",  int'(done),  0);
    check("rst_busy",  int'(busy),  0);
    check("rst_value", int'(value), 0);
    #2;
    reset = 1'b0;
    step();

    // Single-requester intervals: grant pattern and done latency after grant.
    for (int t = 0; t < 5; t++) begin
      wait_idle();
      req = '0;
      req[tbl[t].idx] = 1'b1;
      set_lim(tbl[t].idx, tbl[t].lim);
      step();
      check("tbl_grant", int'(grant), int'(tbl[t].exp_grant));
      check("tbl_val0",  int'(value), 0);
      req = '0;
      cnt = 0;
      while (done == '0 && cnt < 400) begin
        step();
        cnt++;
      end
      check("tbl_done_ofs", cnt, tbl[t].exp_done_ofs);
      check("tbl_done_val", int'(value), tbl[t].lim);
      step();
      check("tbl_busy_low", int'(busy), 0);
      check("tbl_val_hold", int'(value), tbl[t].lim);
    end

    // All requesters held with limit 1: order 0,1,2,3,0 and 4-edge spacing.
    pulse_reset("rr_rst");
    for (int i = 0; i < N; i++) set_lim(i, 1);
    req    = '1;
    prevg  = '0;
    nfound = 0;
    cyc    = 0;
    while (nfound < 5 && cyc < 60) begin
      step();
      cyc++;
      if (grant != '0 && prevg == '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) order[nfound] = i;
        when[nfound] = cyc;
        nfound++;
      end
      prevg = grant;
    end
    check("rr_count", nfound, 5);
    for (int k = 0; k < 5; k++) check("rr_order", order[k], k % N);
    for (int k = 1; k < 5; k++) check("rr_gap", when[k] - when[k-1], 4);
    req = '0;
    wait_idle();

    // Request and limit change during RUN do not disturb the interval.
    pulse_reset("drop_rst");
    req = 4'b0001;
    set_lim(0, 6);
    step();
    step();
    step();
    req = '0;
    set_lim(0, 1);
    cnt = 2;
    while (done == '0 && cnt < 400) begin
      step();
      cnt++;
    end
    check("drop_done", int'(done), 1);
    check("drop_ofs", cnt, 7);
    check("drop_val", int'(value), 6);
    wait_idle();

    // Reset mid-RUN at value 5 of 20, then a fresh grant to requester 1.
    pulse_reset("mid_pre");
    req = 4'b0001;
    set_lim(0, 20);
    step();
    req = '0;
    wait_value(5);
    pulse_reset("mid_rst");
    req = 4'b0010;
    set_lim(1, 3);
    step();
    check("mid_grant", int'(grant), 2);
    check("mid_val0",  int'(value), 0);
    req = '0;
    wait_idle();

    // A requester that just finished loses to any other pending request.
    req = 4'b0100;
    set_lim(2, 0);
    step();
    req = 4'b0101;
    set_lim(0, 0);
    wait_idle();
    step();
    check("fair_grant", int'(grant), 1);
    req = '0;
    wait_idle();

`ifdef COUNTER_ARBITER_ABORT_EN
    // Abort at value 4 of 10 forces completion with the count held.
    req = 4'b0001;
    set_lim(0, 10);
    step();
    req = '0;
    wait_value(4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done",    int'(done),    1);
    check("abort_flag",    int'(aborted), 1);
    check("abort_val",     int'(value),   4);
    step();
    check("abort_clear",   int'(aborted), 0);
    wait_idle();
    // Abort coinciding with the terminal count is a normal completion.
    req = 4'b0010;
    set_lim(1, 10);
    step();
    req = '0;
    wait_value(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_tc_done", int'(done),    2);
    check("abort_tc_flag", int'(aborted), 0);
    wait_idle();
`endif

    // Randomized traffic compared cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 15) == 0) set_lim(i, 255);
          else set_lim(i, int'($urandom_range(0, 12)));
        end
      end
      abort = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset("rnd_rst");
      step();
    end
    abort = 1'b0;
    req   = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Time-shares one up-counter between `N_REQ` requesters. Each requester asks for a counting interval with a terminal count. The block grants requesters round-robin, runs the counter from 0 to the granted terminal count, and then returns a one-cycle `done` pulse to the winner. It sits between the counter datapath and client logic that needs timed intervals, so clients never drive the counter directly.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: counter and terminal-count width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `req_limit`  in  N_REQ*WIDTH  terminal counts; slice i = `[i*WIDTH +: WIDTH]`.
- `grant`  out  N_REQ  one-hot (or zero) owner of the counter; registered.
- `done`  out  N_REQ  one-cycle completion pulse to the owner; registered.
- `busy`  out  1  high whenever state is not IDLE.
- `value`  out  WIDTH  current counter value.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any `req` is high at an edge, the round-robin winner is chosen.
  - `grant` gets the winner's one-hot, `lim_q` gets its `req_limit` slice, `value` gets 0, state goes to RUN.
  - `req_limit` is sampled only at this edge.
- RUN, at each edge:
  - If `value == lim_q`: state goes to DONE and `value` holds.
  - Otherwise `value` increments by 1.
  - `value` never wraps; the largest limit is 2^WIDTH-1.
- DONE:
  - `done[winner]` is high for exactly this one cycle; `grant` stays high.
  - At the next edge `grant` clears and state goes to IDLE.
- `value` holds its last count in IDLE until the next grant.
- Round-robin:
  - The pointer records the last winner.
  - Search starts at pointer+1 and wraps modulo N_REQ.
  - After reset, requester 0 has highest priority.
- Grant lifetime:
  - A grant runs to completion even if `req` drops during RUN; `req` is not sampled outside IDLE.
  - A requester still holding `req` in IDLE after its `done` competes normally. It cannot win again while any other `req` is high.
- Reset (asynchronous, any state, including mid-RUN):
  - state IDLE, `grant` 0, `done` 0, `busy` 0, `value` 0, pointer such that requester 0 is next.
  - No `done` pulse is produced for the interrupted interval.

## Timing
- Grant edge E: `grant` and `busy` are high from E. `value` is 0 in the cycle after E.
- `value` equals k in cycle E+k. DONE is entered at edge E+L+1, where L = `lim_q`.
- `done` is high in cycle E+L+1 only. `grant` and `busy` fall at edge E+L+2.
- Total occupancy is L+2 cycles; for L=0 it is 2 cycles.
- Back-to-back: the earliest next grant edge is E+L+3, since at least one IDLE cycle separates grants.
- Request-to-grant latency from IDLE is 1 edge. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `COUNTER_ARBITER_ABORT_EN`.
- With the macro defined:
  - Adds input `abort` (1) and output `aborted` (1, registered).
  - `abort` high at an edge in RUN forces DONE with `value` held.
  - `aborted` is high together with `done` during that DONE cycle only.
  - If `abort` is high at the same edge where `value == lim_q`, the interval is a normal completion and `aborted` stays 0.
  - `abort` is ignored in IDLE and DONE.
- Undefined: neither port exists, and every grant runs to its terminal count.

## Structure
- Package `counter_arbiter_pkg`:
  - state enum `arb_state_t` (IDLE, RUN, DONE);
  - `COUNTER_ARB_WIDTH_DEF`=8;
  - `COUNTER_ARB_NREQ_DEF`=4.
- Sub-module `rr_arbiter`:
  - combinational one-hot winner from `req` and the pointer;
  - pointer register updated on grant.
- The FSM, `lim_q` register and counter stay in `counter_arbiter`.

## Test plan
- Reset pulse mid-RUN, at `value`=5 with limit 20 → all outputs 0 immediately, no `done`; the next `req[1]` gets a fresh grant with `value` starting at 0.
- Single `req[2]` with limit 3 → `grant`=0100 at E, `value` 0,1,2,3 over cycles E..E+3, `done`=0100 in cycle E+4, `busy` low from E+5.
- Limit 0 and limit 255 (WIDTH=8) → `done` at E+1 and E+256 respectively; `value` never exceeds the limit and never wraps.
- All four `req` held high with limit 1 → grant order 0,1,2,3,0; each occupancy is 3 cycles plus 1 IDLE cycle.
- `req[0]` dropped during RUN → the interval still completes and `done[0]` still pulses; `req_limit` changes during RUN have no effect.
- With `COUNTER_ARBITER_ABORT_EN`, limit 10, `abort` at `value`=4 → DONE with `value`=4 and `done` plus `aborted` for 1 cycle. `abort` at `value`=10 → `aborted`=0.
